// File: rtl/nonce_scan.sv
// -----------------------------------------------------------------------------
// nonce_scan
//
// Sequential nonce byte scanner. A start pulse (inicio) latches an N_BYTES-wide
// nonce. The block then examines one byte per clock, from byte 0 (the MSB end
// of the nonce bus) toward byte N_BYTES-1. It stops at the first byte that is
// not SKIP and reports that byte, its index and how many bytes have been
// examined since the start. A resume pulse (siguiente) continues the scan
// after the last hit. Downstream logic can therefore walk every usable byte
// of one nonce without reloading it.
//
// Handshake: inicio and siguiente are single-cycle request pulses, sampled on
// the rising edge of clk_a. inicio is accepted in IDLE and DONE. siguiente is
// accepted only in DONE. Both are ignored while busy_out is high. A result is
// meaningful only while valid_out is high. valid_out and busy_out are never
// high together, and both are low in IDLE.
//
// Parameters
//   N_BYTES  bytes per nonce (at least 2)
//   W        bits per byte
//   IDX_W    index width, 2**IDX_W >= N_BYTES
//   SKIP     byte value that is passed over
//   FILL     byte reported once no usable byte remains
//
// Ports
//   clk_a          in   clock, rising edge
//   reset_L        in   asynchronous active-low reset
//   inicio         in   start pulse: latch nonce, begin a fresh scan
//   siguiente      in   resume pulse: continue from idx_out+1
//   nonce          in   [0:N_BYTES*W-1], byte k = bits [k*W : k*W+W-1]
//   byte_out       out  selected byte (FILL when none remains)
//   idx_out        out  index of the selected byte
//   count_out      out  bytes examined since the last accepted inicio
//   not_found_out  out  no byte other than SKIP remains
//   valid_out      out  result outputs are stable and meaningful
//   busy_out       out  scan in progress
//   state_dbg      out  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// -----------------------------------------------------------------------------
module nonce_scan #(
    parameter int             N_BYTES = 4,
    parameter int             W       = 8,
    parameter int             IDX_W   = 2,
    parameter logic [W-1:0]   SKIP    = 8'hff,
    parameter logic [W-1:0]   FILL    = 8'hfe
) (
    input  logic                 clk_a,
    input  logic                 reset_L,
    input  logic                 inicio,
    input  logic                 siguiente,
    input  logic [0:N_BYTES*W-1] nonce,
    output logic [W-1:0]         byte_out,
    output logic [IDX_W-1:0]     idx_out,
    output logic [IDX_W:0]       count_out,
    output logic                 not_found_out,
    output logic                 valid_out,
    output logic                 busy_out,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W:0]   COUNT_MAX = (IDX_W + 1)'(N_BYTES);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [W-1:0]       nonce_q [N_BYTES];

    logic [W-1:0]       cur_byte;
    logic               cur_usable;
    logic [IDX_W:0]     count_inc;
    logic               start_accept;

    // Byte under examination this cycle. ptr is kept within 0..N_BYTES-1, so
    // the lookup never leaves the latched array.
    always_comb begin
        cur_byte   = nonce_q[ptr];
        cur_usable = (cur_byte != SKIP);
    end

    // count_out cannot pass N_BYTES. Each byte is examined at most once per
    // nonce, so the saturation only guards against wrap.
    always_comb begin
        count_inc = count_out;
        if (count_out != COUNT_MAX) begin
            count_inc = count_out + 1'b1;
        end
    end

    // inicio is honoured in IDLE and DONE and takes precedence over siguiente.
    // While a scan is running it is ignored.
    always_comb begin
        start_accept = inicio && ((state == IDLE) || (state == DONE));
    end

    assign state_dbg = state;

    always_ff @(posedge clk_a or negedge reset_L) begin
        if (!reset_L) begin
            state         <= IDLE;
            ptr           <= '0;
            byte_out      <= '0;
            idx_out       <= '0;
            count_out     <= '0;
            not_found_out <= 1'b0;
            valid_out     <= 1'b0;
            busy_out      <= 1'b0;
            for (int k = 0; k < N_BYTES; k++) begin
                nonce_q[k] <= '0;
            end
        end else if (start_accept) begin
            // Fresh scan: the nonce is sampled only here.
            for (int k = 0; k < N_BYTES; k++) begin
                nonce_q[k] <= nonce[k*W +: W];
            end
            ptr           <= '0;
            byte_out      <= '0;
            idx_out       <= '0;
            count_out     <= '0;
            not_found_out <= 1'b0;
            valid_out     <= 1'b0;
            busy_out      <= 1'b1;
            state         <= SCAN;
        end else begin
            case (state)
                IDLE: begin
                    // Waiting for inicio. siguiente has no meaning here.
                    state <= IDLE;
                end

                SCAN: begin
                    count_out <= count_inc;
                    if (cur_usable) begin
                        byte_out      <= cur_byte;
                        idx_out       <= ptr;
                        not_found_out <= 1'b0;
                        busy_out      <= 1'b0;
                        valid_out     <= 1'b1;
                        state         <= DONE;
                    end else if (ptr < LAST_IDX) begin
                        ptr <= ptr + 1'b1;
                    end else begin
                        // Ran off the end with nothing usable.
                        byte_out      <= FILL;
                        idx_out       <= LAST_IDX;
                        not_found_out <= 1'b1;
                        busy_out      <= 1'b0;
                        valid_out     <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    if (siguiente && !not_found_out) begin
                        if (idx_out < LAST_IDX) begin
                            ptr       <= idx_out + 1'b1;
                            busy_out  <= 1'b1;
                            valid_out <= 1'b0;
                            state     <= SCAN;
                        end else begin
                            // The last hit was the final byte, so nothing is
                            // left to examine. Report exhaustion in place. The
                            // count does not move because no byte was examined.
                            byte_out      <= FILL;
                            not_found_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy_out  <= 1'b0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scan.sv
// -----------------------------------------------------------------------------
// tb_nonce_scan
//
// Bench for nonce_scan. It runs two instances: a 4-byte one (IDX_W=2) and an
// 8-byte one (IDX_W=3). A select signal routes the pulses to one instance and
// picks which instance's outputs are observed. Fixed vectors and hand-written
// sequences carry literal expectations. The randomized section uses a
// byte-list search model.
// -----------------------------------------------------------------------------
module tb_nonce_scan;

    localparam logic [7:0] SKIP_B = 8'hff;
    localparam logic [7:0] FILL_B = 8'hfe;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_L;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        inicio;
    logic        siguiente;
    logic        sel;        // 0: 4-byte instance, 1: 8-byte instance
    logic [63:0] nonce_v;

    logic        inicio4, siguiente4, inicio8, siguiente8;
    assign inicio4    = inicio & ~sel;
    assign siguiente4 = siguiente & ~sel;
    assign inicio8    = inicio & sel;
    assign siguiente8 = siguiente & sel;

    logic [7:0] byte4, byte8;
    logic [1:0] idx4;
    logic [2:0] idx8;
    logic [2:0] count4;
    logic [3:0] count8;
    logic       nf4, nf8, valid4, valid8, busy4, busy8;
    logic [1:0] st4, st8;

    nonce_scan #(.N_BYTES(4), .W(8), .IDX_W(2), .SKIP(8'hff), .FILL(8'hfe)) dut4 (
        .clk_a         (clk),
        .reset_L       (reset_L),
        .inicio        (inicio4),
        .siguiente     (siguiente4),
        .nonce         (nonce_v[31:0]),
        .byte_out      (byte4),
        .idx_out       (idx4),
        .count_out     (count4),
        .not_found_out (nf4),
        .valid_out     (valid4),
        .busy_out      (busy4),
        .state_dbg     (st4)
    );

    nonce_scan #(.N_BYTES(8), .W(8), .IDX_W(3), .SKIP(8'hff), .FILL(8'hfe)) dut8 (
        .clk_a         (clk),
        .reset_L       (reset_L),
        .inicio        (inicio8),
        .siguiente     (siguiente8),
        .nonce         (nonce_v),
        .byte_out      (byte8),
        .idx_out       (idx8),
        .count_out     (count8),
        .not_found_out (nf8),
        .valid_out     (valid8),
        .busy_out      (busy8),
        .state_dbg     (st8)
    );

    logic [7:0] byte_o;
    logic [2:0] idx_o;
    logic [3:0] count_o;
    logic       nf_o, valid_o, busy_o;
    assign byte_o  = sel ? byte8  : byte4;
    assign idx_o   = sel ? idx8   : {1'b0, idx4};
    assign count_o = sel ? count8 : {1'b0, count4};
    assign nf_o    = sel ? nf8    : nf4;
    assign valid_o = sel ? valid8 : valid4;
    assign busy_o  = sel ? busy8  : busy4;

    // ---------------- bookkeeping ----------------
    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model holds the nonce as a list of bytes and finds the next usable
    // one with a plain search. m_lat is the number of clock edges from the
    // accepting edge until the result is valid.
    int         m_n;
    logic [7:0] m_b [8];
    logic [7:0] m_byte;
    int         m_idx;
    int         m_count;
    bit         m_nf;
    bit         m_scan;
    int         m_lat;

    function automatic void model_scan_from(input int from);
        m_scan = 1'b1;
        for (int k = from; k < m_n; k++) begin
            m_count++;
            if (m_b[k] != SKIP_B) begin
                m_byte = m_b[k];
                m_idx  = k;
                m_nf   = 1'b0;
                m_lat  = k - from + 1;
                return;
            end
        end
        m_byte = FILL_B;
        m_idx  = m_n - 1;
        m_nf   = 1'b1;
        m_lat  = m_n - from;
    endfunction

    function automatic void model_start();
        m_count = 0;
        model_scan_from(0);
    endfunction

    function automatic void model_resume();
        m_scan = 1'b0;
        m_lat  = 0;
        if (!m_nf) begin
            if (m_idx == m_n - 1) begin
                m_byte = FILL_B;
                m_nf   = 1'b1;
            end else begin
                model_scan_from(m_idx + 1);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Value v is right-aligned: byte 0 is the most significant of the n bytes.
    task automatic load_nonce(input logic [63:0] v, input int n);
        sel     = (n == 8);
        nonce_v = v;
        m_n     = n;
        for (int k = 0; k < n; k++) begin
            m_b[k] = v[(n - 1 - k) * 8 +: 8];
        end
    endtask

    // Drives the pulse for one clock. On return the accepting edge has passed
    // and we sit on the following falling edge.
    task automatic pulse(input bit st, input bit nx);
        @(negedge clk);
        inicio    = st;
        siguiente = nx;
        @(negedge clk);
        inicio    = 1'b0;
        siguiente = 1'b0;
    endtask

    task automatic wait_valid(input int c0, input int exp_lat, input string name);
        int c;
        int overlap;
        c       = c0;
        overlap = 0;
        while (!valid_o && c < 40) begin
            @(negedge clk);
            c++;
            if (valid_o && busy_o) overlap++;
        end
        chk({name, "_latency"}, c, exp_lat);
        chk({name, "_exclusive"}, overlap, 0);
    endtask

    task automatic check_out(input string name, input logic [7:0] b, input int idx,
                             input int cnt, input bit nf);
        chk({name, "_byte"},  int'(byte_o),  int'(b));
        chk({name, "_idx"},   int'(idx_o),   idx);
        chk({name, "_count"}, int'(count_o), cnt);
        chk({name, "_nf"},    int'(nf_o),    int'(nf));
        chk({name, "_valid"}, int'(valid_o), 1);
        chk({name, "_busy"},  int'(busy_o),  0);
    endtask

    task automatic scan_and_check(input string name, input bit st, input bit nx,
                                  input bit exp_scan, input int lat,
                                  input logic [7:0] b, input int idx, input int cnt,
                                  input bit nf);
        pulse(st, nx);
        if (exp_scan) begin
            chk({name, "_busy_on_accept"},  int'(busy_o),  1);
            chk({name, "_valid_on_accept"}, int'(valid_o), 0);
            wait_valid(0, lat, name);
        end
        check_out(name, b, idx, cnt, nf);
    endtask

    task automatic run_step(input bit st, input bit nx, input string name);
        if (st) model_start();
        else    model_resume();
        scan_and_check(name, st, nx, m_scan, m_lat, m_byte, m_idx, m_count, m_nf);
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_byte"},  int'(byte_o),  0);
        chk({name, "_idx"},   int'(idx_o),   0);
        chk({name, "_count"}, int'(count_o), 0);
        chk({name, "_nf"},    int'(nf_o),    0);
        chk({name, "_valid"}, int'(valid_o), 0);
        chk({name, "_busy"},  int'(busy_o),  0);
    endtask

    // ---------------- fixed vectors (4-byte instance) ----------------
    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b;
        int          idx;
        int          cnt;
        bit          nf;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{32'h12ffffff, 8'h12, 0, 1, 1'b0, 1};
        vecs[1] = '{32'hffff34ff, 8'h34, 2, 3, 1'b0, 3};
        vecs[2] = '{32'hff01ff02, 8'h01, 1, 2, 1'b0, 2};
        vecs[3] = '{32'hffffffff, 8'hfe, 3, 4, 1'b1, 4};
        vecs[4] = '{32'hfffffffe, 8'hfe, 3, 4, 1'b0, 4};
        vecs[5] = '{32'h00000000, 8'h00, 0, 1, 1'b0, 1};

        inicio    = 1'b0;
        siguiente = 1'b0;
        sel       = 1'b0;
        nonce_v   = '0;
        m_n       = 4;
        reset_L   = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset4");
        chk("reset_state4", int'(st4), 0);
        chk("reset_state8", int'(st8), 0);
        reset_L = 1'b1;
        @(negedge clk);

        // siguiente in IDLE does nothing
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check_cleared("idle_sig");

        // table-driven fresh scans
        for (int i = 0; i < 6; i++) begin
            load_nonce({32'h0, vecs[i].nonce}, 4);
            scan_and_check($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b1, vecs[i].lat,
                           vecs[i].b, vecs[i].idx, vecs[i].cnt, vecs[i].nf);
        end

        // late hit then resume runs off the end
        load_nonce(64'hffff34ff, 4);
        scan_and_check("late_hit", 1'b1, 1'b0, 1'b1, 3, 8'h34, 2, 3, 1'b0);
        scan_and_check("late_resume", 1'b0, 1'b1, 1'b1, 1, 8'hfe, 3, 4, 1'b1);

        // walk every usable byte
        load_nonce(64'hff01ff02, 4);
        scan_and_check("walk_a", 1'b1, 1'b0, 1'b1, 2, 8'h01, 1, 2, 1'b0);
        scan_and_check("walk_b", 1'b0, 1'b1, 1'b1, 2, 8'h02, 3, 4, 1'b0);
        scan_and_check("walk_end", 1'b0, 1'b1, 1'b0, 0, 8'hfe, 3, 4, 1'b1);
        scan_and_check("walk_ignored", 1'b0, 1'b1, 1'b0, 0, 8'hfe, 3, 4, 1'b1);
        repeat (5) @(negedge clk);
        check_out("done_hold", 8'hfe, 3, 4, 1'b1);

        // all SKIP, and the resume afterwards is ignored
        load_nonce(64'hffffffff, 4);
        scan_and_check("all_skip", 1'b1, 1'b0, 1'b1, 4, 8'hfe, 3, 4, 1'b1);
        scan_and_check("all_skip_sig", 1'b0, 1'b1, 1'b0, 0, 8'hfe, 3, 4, 1'b1);

        // inicio together with siguiente in DONE: fresh scan, count restarts
        load_nonce(64'hffff34ff, 4);
        scan_and_check("both4", 1'b1, 1'b1, 1'b1, 3, 8'h34, 2, 3, 1'b0);

        // inicio during SCAN ignored, nonce changes after the start ignored
        load_nonce(64'hffff34ff, 4);
        pulse(1'b1, 1'b0);
        chk("scan_ini_busy", int'(busy_o), 1);
        inicio  = 1'b1;
        nonce_v = 64'h0;
        @(negedge clk);
        inicio  = 1'b0;
        wait_valid(1, 3, "scan_ini");
        check_out("scan_ini", 8'h34, 2, 3, 1'b0);
        scan_and_check("scan_ini_resume", 1'b0, 1'b1, 1'b1, 1, 8'hfe, 3, 4, 1'b1);

        // asynchronous reset mid-scan
        load_nonce(64'hffffffff, 4);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        #1;
        reset_L = 1'b0;
        #1;
        check_cleared("rst_async");
        chk("rst_state", int'(st4), 0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (6) @(negedge clk);
        check_cleared("rst_stays_idle");
        load_nonce(64'h12ffffff, 4);
        scan_and_check("after_rst", 1'b1, 1'b0, 1'b1, 1, 8'h12, 0, 1, 1'b0);

        // 8-byte instance
        load_nonce(64'hffffffffffff56ff, 8);
        scan_and_check("n8_late", 1'b1, 1'b0, 1'b1, 7, 8'h56, 6, 7, 1'b0);
        scan_and_check("n8_resume", 1'b0, 1'b1, 1'b1, 1, 8'hfe, 7, 8, 1'b1);
        load_nonce(64'hffffffffffffffff, 8);
        scan_and_check("n8_all_skip", 1'b1, 1'b0, 1'b1, 8, 8'hfe, 7, 8, 1'b1);
        load_nonce(64'h01ffffffffffff99, 8);
        scan_and_check("n8_both", 1'b1, 1'b1, 1'b1, 1, 8'h01, 0, 1, 1'b0);
        scan_and_check("n8_walk", 1'b0, 1'b1, 1'b1, 7, 8'h99, 7, 8, 1'b0);
        scan_and_check("n8_walk_end", 1'b0, 1'b1, 1'b0, 0, 8'hfe, 7, 8, 1'b1);

        // randomized runs against the search model
        for (int it = 0; it < 60; it++) begin
            int          n;
            int          resumes;
            logic [63:0] v;
            n = ($urandom_range(0, 1) == 1) ? 8 : 4;
            v = '0;
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 9) < 6) ? SKIP_B : 8'($urandom_range(0, 255));
                v = {v[55:0], b};
            end
            load_nonce(v, n);
            run_step(1'b1, 1'b0, $sformatf("rnd%0d_start", it));
            resumes = $urandom_range(0, n + 1);
            for (int r = 0; r < resumes; r++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 5) == 0) begin
                    v = {$urandom, $urandom};
                    if (n == 4) v[63:32] = '0;
                    load_nonce(v, n);
                    run_step(1'b1, 1'b1, $sformatf("rnd%0d_both%0d", it, r));
                end else begin
                    run_step(1'b0, 1'b1, $sformatf("rnd%0d_res%0d", it, r));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/nonce_scan.md
# nonce_scan

Parametrised, sequential successor of the single-cycle nonce byte selector. It latches an N_BYTES-wide nonce on a start pulse and scans one byte per clock from byte 0 (MSB end) toward byte N_BYTES-1. It stops at the first byte not equal to SKIP and reports that byte, its index and the bytes-examined count. A resume request continues the scan after the last hit, so the downstream mining logic can walk every usable byte of one nonce without reloading it.

## Interface
- N_BYTES, 4, bytes per nonce; must be at least 2.
- W, 8, bits per byte.
- IDX_W, 2, index width; must satisfy 2**IDX_W >= N_BYTES.
- SKIP, 8'hff, byte value to skip (W bits).
- FILL, 8'hfe, byte reported when no usable byte remains (W bits).
- clk_a  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- inicio  input  1  start pulse; latches nonce and begins a fresh scan.
- siguiente  input  1  resume pulse; continues the scan from idx_out+1.
- nonce  input  N_BYTES*W  nonce, [0:N_BYTES*W-1]; byte k occupies bits [k*W : k*W+W-1].
- byte_out  output  W  selected byte.
- idx_out  output  IDX_W  index of the selected byte.
- count_out  output  IDX_W+1  bytes examined since the last inicio.
- not_found_out  output  1  no byte other than SKIP remains.
- valid_out  output  1  results are stable and meaningful.
- busy_out  output  1  scan in progress.

## Operation
- Reset (reset_L=0, asynchronous) forces state IDLE and clears the pointer, the latched nonce and all outputs to 0.
- States: IDLE, SCAN, DONE.
- **IDLE:**
  - inicio=1 latches nonce, clears byte_out, idx_out, count_out and not_found_out, sets ptr=0, and moves to SCAN.
  - siguiente is ignored.
- **SCAN** (busy_out=1, valid_out=0). Each cycle examines latched byte[ptr] and increments count_out.
  - byte[ptr] != SKIP: byte_out=byte[ptr], idx_out=ptr, not_found_out=0, go to DONE.
  - byte[ptr] == SKIP and ptr < N_BYTES-1: ptr increments, stay in SCAN.
  - byte[ptr] == SKIP and ptr == N_BYTES-1: byte_out=FILL, idx_out=N_BYTES-1, not_found_out=1, go to DONE.
  - inicio and siguiente are ignored while in SCAN.
- **DONE** (valid_out=1, busy_out=0). Outputs hold.
  - inicio=1 restarts exactly as from IDLE. If inicio and siguiente are high together, inicio wins.
  - siguiente=1 with not_found_out=0 and idx_out < N_BYTES-1: ptr=idx_out+1, go to SCAN.
  - siguiente=1 with not_found_out=0 and idx_out == N_BYTES-1: next cycle byte_out=FILL and not_found_out=1, count_out unchanged, stay in DONE. valid_out stays high.
  - siguiente=1 with not_found_out=1: ignored.
  - With neither input asserted, the block stays in DONE indefinitely.
- Width rules:
  - count_out never exceeds N_BYTES; no wrap.
  - ptr never exceeds N_BYTES-1.
- The nonce input is only sampled on an accepted inicio; later changes have no effect.

## Timing
- All outputs are registered.
- **Fresh scan:** inicio is sampled at edge E0. If the first usable byte is at index k, valid_out rises after edge E(k+1), and count_out=k+1.
- **All bytes SKIP:** valid_out rises after E(N_BYTES), with count_out=N_BYTES.
- **Resume:** siguiente is accepted at edge Er with next hit at index j. valid_out drops after Er and rises after edge Er+(j-idx_out). count_out accumulates across resumes.
- busy_out and valid_out are never high together. Both are low in IDLE.
- Reset asserted mid-SCAN or in DONE:
  - Outputs clear immediately (asynchronously).
  - The scan resumes only on a new inicio after reset_L returns high.
- inicio held high in DONE retriggers every DONE visit. Single-cycle pulses are the intended use.

## Test plan
- **Reset:** reset_L=0 during SCAN → all outputs 0 immediately, state IDLE; inicio after release scans normally.
- **First byte usable** (N_BYTES=4, W=8): nonce=32'h12ffffff, inicio pulse → one cycle later valid_out=1, byte_out=8'h12, idx_out=0, count_out=1, not_found_out=0.
- **Late hit and resume:** nonce=32'hffff34ff, inicio → after 3 cycles byte_out=8'h34, idx_out=2, count_out=3. Then siguiente → after 1 cycle byte_out=8'hfe, idx_out=3, count_out=4, not_found_out=1.
- **Walk every byte:** nonce=32'hff01ff02, inicio then siguiente in each DONE → hits (01, idx 1, count 2), then (02, idx 3, count 4). A final siguiente → FILL, not_found_out=1, count_out=4.
- **All SKIP:** nonce=32'hffffffff → valid_out after 4 cycles with byte_out=8'hfe, idx_out=3, not_found_out=1. A further siguiente is ignored.
- **Precedence:** inicio and siguiente together in DONE → fresh scan of the new nonce with count_out restarted from 0. inicio pulsed during SCAN → ignored. Repeat with N_BYTES=8, IDX_W=3.
